// File: rtl/des_perm_pipe.sv
// DES initial / final permutation (IP, IP^-1) with optional half-swap, carried through a
// LATENCY-deep stall-able pipeline with tag sideband. Optional bypass mode: DES_PERM_BYPASS_EN.
module des_perm_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_swap,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             err,
  output logic [15:0]      done_cnt
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } stage_t;

  // Row r of the IP table starts at 58,60,62,64,57,59,61,63 and steps down by 8 per column.
  // IP^-1 is the inverse mapping of the same table. Bit n (DES numbering) sits at index 64-n.
  function automatic logic [DATA_W-1:0] des_ip(input logic [DATA_W-1:0] x, input logic inverse);
    logic [DATA_W-1:0] r;
    int                row;
    int                src;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      row = i / 8;
      src = ((row < 4) ? (58 + 2 * row) : (57 + 2 * (row - 4))) - 8 * (i % 8);
      if (inverse) r[6'(64 - src)] = x[6'(63 - i)];
      else         r[6'(63 - i)]   = x[6'(64 - src)];
    end
    return r;
  endfunction

  logic              advance;
  logic [DATA_W-1:0] pre;
  logic [DATA_W-1:0] perm_c;
  logic              mode_bad;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Input-side permutation; unsupported modes yield zero data and flag an error
  always_comb begin
    perm_c   = '0;
    mode_bad = 1'b0;
    pre      = in_swap ? {in_data[31:0], in_data[63:32]} : in_data;
    case (in_mode)
      2'b00: perm_c = des_ip(pre, 1'b0);
      2'b01: perm_c = des_ip(pre, 1'b1);
`ifdef DES_PERM_BYPASS_EN
      2'b10: perm_c = pre;
`endif
      default: mode_bad = 1'b1;
    endcase
  end

  // Lockstep register chain; flush kills valid bits but leaves data/tag in place
  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    stage_t d;
    stage_t q;
    if (g == 0) begin : g_head
      assign d = '{vld: in_valid, tag: in_tag, data: perm_c};
    end else begin : g_body
      assign d = g_stage[g-1].q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else begin
        if (advance) q <= d;
        if (flush)   q.vld <= 1'b0;
      end
    end
  end

  assign out_valid = g_stage[LATENCY-1].q.vld;
  assign out_data  = g_stage[LATENCY-1].q.data;
  assign out_tag   = g_stage[LATENCY-1].q.tag;

  // Sticky error on any accepted block with an unsupported mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (in_valid && in_ready && mode_bad) begin
      err <= 1'b1;
    end
  end

  // A block flushed while sitting on the output is discarded, not delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready && !flush) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed self-checking bench for des_perm_pipe (LATENCY=2, TAG_W=4).
module tb_des_perm_pipe;

  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic [1:0]       in_mode;
  logic             in_swap;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             err;
  logic [15:0]      done_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

`ifdef DES_PERM_BYPASS_EN
  localparam logic [63:0] EXP_BYP = 64'h89ABCDEF01234567;
`else
  localparam logic [63:0] EXP_BYP = 64'h0;
`endif

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] IPV = 64'hCC00CCFFF0AAF0AA;

  des_perm_pipe #(.LATENCY(2), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_swap   (in_swap),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .err       (err),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic s,
                       input logic [63:0] d, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_mode  = m;
    in_swap  = s;
    in_data  = d;
    in_tag   = t;
  endtask

  task automatic expect_out(input string name, input logic [63:0] d, input logic [TAG_W-1:0] t);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] q[$];
    logic [67:0] e;
    logic [63:0] last_data;
    logic        stalled_prev;
    int          sent;
    int          got;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 64'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // IP of the classic plaintext, two-cycle latency
    drive(1'b1, 2'b00, 1'b0, PT, 4'h5);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ip_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    expect_out("ip", IPV, 4'h5);
    tick();
    @(negedge clk);
    chk("ip_done_cnt", 64'(done_cnt), 64'd1);
    chk("ip_drained", 64'(out_valid), 64'd0);
    tick();

    // IP^-1 with and without swap, back to back
    drive(1'b1, 2'b01, 1'b1, 64'h434232340A4CD995, 4'h6);
    tick();
    drive(1'b1, 2'b01, 1'b0, IPV, 4'h7);
    tick();
    in_valid = 1'b0;
    expect_out("fp_swap", 64'h85E813540F0AB405, 4'h6);
    tick();
    expect_out("fp_noswap", PT, 4'h7);
    tick();
    @(negedge clk);
    chk("fp_done_cnt", 64'(done_cnt), 64'd3);
    tick();

    // Reserved mode, then mode 10
    drive(1'b1, 2'b11, 1'b0, PT, 4'h9);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rsv_err", 64'(err), 64'd1);
    tick();
    expect_out("rsv", 64'h0, 4'h9);
    tick();
    drive(1'b1, 2'b10, 1'b1, PT, 4'hA);
    tick();
    in_valid = 1'b0;
    tick();
    expect_out("byp", EXP_BYP, 4'hA);
    tick();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_done_cnt", 64'(done_cnt), 64'd5);
    tick();

    // Reset asserted with a block sitting on the output
    drive(1'b1, 2'b00, 1'b0, PT, 4'h3);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("prerst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_done_cnt", 64'(done_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Eight blocks with the sink stalled for cycles 3..6
    sent = 0; got = 0; stalled_prev = 1'b0; last_data = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) drive(1'b1, sent[0] ? 2'b01 : 2'b00, 1'b0, sent[0] ? IPV : PT, 4'(sent));
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back({4'(sent), sent[0] ? PT : IPV});
        sent++;
      end
      if (!out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (stalled_prev) chk("stall_stable", out_data, last_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stall_unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("stall_data", out_data, e[63:0]);
          chk("stall_tag", 64'(out_tag), 64'(e[67:64]));
        end
        got++;
      end
      stalled_prev = !out_ready && out_valid;
      last_data    = out_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("stall_delivered", 64'(got), 64'd8);
    chk("stall_done_cnt", 64'(done_cnt), 64'd8);
    tick();

    // Flush with two blocks in flight and a third presented
    drive(1'b1, 2'b00, 1'b0, PT, 4'h1);
    tick();
    drive(1'b1, 2'b00, 1'b0, PT, 4'h2);
    tick();
    drive(1'b1, 2'b00, 1'b0, PT, 4'h3);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid_1", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("flush_valid_2", 64'(out_valid), 64'd0);
    chk("flush_done_cnt", 64'(done_cnt), 64'd8);
    tick();

    // Run done_cnt up to 0xFFFF, then wrap on one more delivery
    drive(1'b1, 2'b00, 1'b0, PT, 4'h0);
    repeat (32'hFFFF - 32'd8) tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("cnt_full", 64'(done_cnt), 64'hFFFF);
    tick();
    drive(1'b1, 2'b00, 1'b0, PT, 4'h0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("cnt_wrap", 64'(done_cnt), 64'h0);
    chk("cnt_wrap_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
